rv32m_muldiv_seq: RTL and testbench
===================================

// Module: rv32m_muldiv_seq
// PURPOSE
//  Multi-cycle sequencer for the RV32M multiply/divide ops, beside the single-cycle RV32I ALU in the back end.
//  Accepts one op via valid/ready and iterates a shift-add / restoring-divide step over the operand magnitudes.
//  Applies sign fix-up and returns the 32-bit result via valid/ready; busy_o stalls the pipeline while it runs.
// PARAMETERS
//  XLEN            32  operand/result width
//  BITS_PER_CYCLE  1   iteration bits per CALC cycle; legal 1,2,4; N = XLEN/BITS_PER_CYCLE
// PORTS
//  clk          in   1     clock; all state on rising edge
//  rst          in   1     synchronous, active-high reset
//  flush_i      in   1     abort the in-flight op, no response
//  req_valid_i  in   1     request valid
//  req_ready_o  out  1     (state==IDLE) & ~flush_i
//  op_i         in   3     MULDIV_OP_t: MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//  rs1_i        in   XLEN  multiplicand / dividend
//  rs2_i        in   XLEN  multiplier / divisor
//  rsp_valid_o  out  1     result valid; held until rsp_ready_i
//  rsp_ready_i  in   1     consumer accepts result
//  result_o     out  XLEN  result; stable while rsp_valid_o & ~rsp_ready_i
//  busy_o       out  1     state != IDLE
// BEHAVIOUR
//  Reset: state IDLE; rsp_valid_o=0, result_o=0, busy_o=0; req_ready_o=1 unless flush_i.
//  Accept: req_valid_i & req_ready_o on edge t. Latch op, magnitudes, and sign flags. Counter = N.
//  FSM: IDLE -> CALC on accept.
//       CALC: one step per cycle, counter decrements; leaves after N cycles (t+1..t+N) -> SIGN.
//       SIGN: one cycle, conditional negation / special-case select -> DONE.
//       DONE: rsp_valid_o=1 from cycle t+N+2 (34 for defaults); -> IDLE on rsp_ready_i.
//  No request is accepted in CALC/SIGN/DONE. After DONE->IDLE, the earliest new accept is the following cycle.
//  Signedness: MULH both signed; MULHSU rs1 signed, rs2 unsigned; MULHU, DIVU, REMU unsigned; DIV/REM signed.
//  Multiply: 2*XLEN unsigned magnitude product, negated if operand signs differ.
//    MUL returns [XLEN-1:0]; MULH* return [2*XLEN-1:XLEN].
//  Divide: restoring divide on magnitudes. Quotient negated if signs differ. Remainder takes the dividend's sign.
//  Divide by zero: DIV/DIVU -> all ones; REM/REMU -> rs1 (unaltered).
//  Signed overflow (DIV 0x80000000 / -1): quotient 0x80000000, REM 0.
//  flush_i or rst in any state: IDLE next cycle. rsp_valid_o drops, no response, in-flight op discarded.
//  flush_i wins over a same-cycle req_valid_i and over a same-cycle rsp_ready_i.
// CONFIGURATION
//  RV32M_DIV_SHORTCUT_EN defined: divide-by-zero and signed-overflow ops go IDLE->DONE directly.
//    rsp_valid_o is then high 1 cycle after accept.
//  Not defined: these ops take the full N+2 latency. Results are identical either way.
// STRUCTURE
//  be_pkg: MULDIV_OP_t enum, MULDIV_STATE_t {IDLE,CALC,SIGN,DONE}.
//  be_pkg: constants MULDIV_DIV0_Q='1, MULDIV_OVF_Q=32'h8000_0000.
//  Sub-module muldiv_step: combinational single-bit add-shift/subtract-shift.
//    Instantiated BITS_PER_CYCLE times in a chain.
// TESTING
//  1 MUL 7 * -3 -> 0xFFFFFFEB; rsp_valid_o rises exactly 34 cycles after accept; busy_o high throughout.
//  2 MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
//    MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
//  3 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  4 DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
//    Latency 1 with RV32M_DIV_SHORTCUT_EN, 34 without.
//  5 rsp_ready_i low 5 cycles in DONE: result_o stable, req_ready_o low.
//    Then ready high -> IDLE next cycle; back-to-back op accepted and correct.
//  6 flush_i in CALC cycle 10 -> busy_o low next cycle, no rsp_valid_o.
//    rst mid-op behaves the same; a following MULHU still returns the correct value.

Source files
------------

// File: rtl/be_pkg.sv
// ----------------------------------------------------------------------------
// be_pkg
// Shared types and constants for the back-end RV32M multiply/divide sequencer.
//   MULDIV_OP_t    : RV32M operation encoding (matches funct3 order).
//   MULDIV_STATE_t : sequencer state, with IDLE/CALC/SIGN/DONE constants.
//   MULDIV_DIV0_Q  : quotient returned for a divide by zero.
//   MULDIV_OVF_Q   : quotient returned for signed overflow (MIN / -1).
//   op_signed_a/b, op_is_div : per-op decode helpers.
// ----------------------------------------------------------------------------
package be_pkg;

   typedef enum logic [2:0] {
      MUL    = 3'd0,
      MULH   = 3'd1,
      MULHSU = 3'd2,
      MULHU  = 3'd3,
      DIV    = 3'd4,
      DIVU   = 3'd5,
      REM    = 3'd6,
      REMU   = 3'd7
   } MULDIV_OP_t;

   typedef logic [1:0] MULDIV_STATE_t;

   localparam MULDIV_STATE_t IDLE = 2'd0;
   localparam MULDIV_STATE_t CALC = 2'd1;
   localparam MULDIV_STATE_t SIGN = 2'd2;
   localparam MULDIV_STATE_t DONE = 2'd3;

   localparam logic [31:0] MULDIV_DIV0_Q = '1;
   localparam logic [31:0] MULDIV_OVF_Q  = 32'h8000_0000;

   // rs1 is interpreted as signed
   function automatic logic op_signed_a(input MULDIV_OP_t op);
      return op inside {MULH, MULHSU, DIV, REM};
   endfunction

   // rs2 is interpreted as signed
   function automatic logic op_signed_b(input MULDIV_OP_t op);
      return op inside {MULH, DIV, REM};
   endfunction

   function automatic logic op_is_div(input MULDIV_OP_t op);
      return op inside {DIV, DIVU, REM, REMU};
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// ----------------------------------------------------------------------------
// muldiv_step
// One combinational iteration bit of the shared multiply/divide datapath.
// A single adder serves both modes:
//   multiply (is_div=0): {hi,lo} holds partial product / multiplier; adds the
//                        multiplicand into hi when lo[0] is set, then shifts
//                        the pair right by one.
//   divide   (is_div=1): {hi,lo} holds partial remainder / dividend; shifts
//                        left by one, trial-subtracts the divisor, keeps the
//                        difference when it does not borrow, and shifts the
//                        quotient bit into lo.
// Ports:
//   is_div   in   1     select divide step
//   hi, lo   in   XLEN  current accumulator halves
//   operand  in   XLEN  multiplicand / divisor magnitude
//   hi_next  out  XLEN  next high half
//   lo_next  out  XLEN  next low half
// ----------------------------------------------------------------------------
module muldiv_step #(
   parameter int XLEN = 32
) (
   input  logic            is_div,
   input  logic [XLEN-1:0] hi,
   input  logic [XLEN-1:0] lo,
   input  logic [XLEN-1:0] operand,
   output logic [XLEN-1:0] hi_next,
   output logic [XLEN-1:0] lo_next
);

   logic [XLEN:0]   shifted;
   logic [XLEN:0]   add_a;
   logic [XLEN:0]   add_b;
   logic [XLEN+1:0] sum;
   logic            no_borrow;

   // NOTE: combinational logic uses blocking assignments and assigns every
   // output on every path, so no latch can be inferred.
   always_comb begin
      shifted   = {hi, lo[XLEN-1]};
      add_a     = is_div ? shifted : {1'b0, hi};
      // Subtraction is done as add of the complement plus carry-in.
      add_b     = is_div ? ~{1'b0, operand} : (lo[0] ? {1'b0, operand} : '0);
      sum       = {1'b0, add_a} + {1'b0, add_b} + {{(XLEN+1){1'b0}}, is_div};
      // Carry out of the extended sum means shifted >= divisor.
      no_borrow = sum[XLEN+1];
      if (is_div) begin
         hi_next = no_borrow ? sum[XLEN-1:0] : shifted[XLEN-1:0];
         lo_next = {lo[XLEN-2:0], no_borrow};
      end else begin
         hi_next = sum[XLEN:1];
         lo_next = {sum[0], lo[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/rv32m_muldiv_seq.sv
// ----------------------------------------------------------------------------
// rv32m_muldiv_seq
// Multi-cycle RV32M multiply/divide sequencer. Takes one op over valid/ready,
// iterates shift-add / restoring-divide steps on operand magnitudes, applies
// the sign fix-up, and returns the result over valid/ready.
// Optional build macro:
//   RV32M_DIV_SHORTCUT_EN : divide-by-zero and signed-overflow divides go
//                           straight from IDLE to DONE (result one cycle
//                           after accept). Results are identical either way.
// Ports:
//   clk          in   1     clock
//   rst          in   1     synchronous active-high reset
//   flush_i      in   1     abort in-flight op, no response
//   req_valid_i  in   1     request valid
//   req_ready_o  out  1     ready to accept (IDLE and no flush)
//   op_i         in   3     MULDIV_OP_t
//   rs1_i        in   XLEN  multiplicand / dividend
//   rs2_i        in   XLEN  multiplier / divisor
//   rsp_valid_o  out  1     result valid, held until rsp_ready_i
//   rsp_ready_i  in   1     consumer accepts result
//   result_o     out  XLEN  result
//   busy_o       out  1     op in progress
// ----------------------------------------------------------------------------
module rv32m_muldiv_seq
   import be_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush_i,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   output logic            rsp_valid_o,
   input  logic            rsp_ready_i,
   output logic [XLEN-1:0] result_o,
   output logic            busy_o
);

   localparam int N     = XLEN / BITS_PER_CYCLE;
   localparam int CNT_W = $clog2(N + 1);

   localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

   MULDIV_STATE_t   state;
   logic [XLEN-1:0] result_q;

   MULDIV_OP_t      op_q;
   logic            neg_a_q;     // dividend/rs1 was negative
   logic            neg_res_q;   // operand signs differ
   logic            div0_q;
   logic            ovf_q;
   logic [XLEN-1:0] hi_q;
   logic [XLEN-1:0] lo_q;
   logic [XLEN-1:0] b_q;
   logic [CNT_W-1:0] cnt_q;

   // Request decode
   MULDIV_OP_t      op_in;
   logic            accept;
   logic            neg_a_in;
   logic            neg_b_in;
   logic            div0_in;
   logic            ovf_in;
   logic [XLEN-1:0] mag_a;
   logic [XLEN-1:0] mag_b;

   assign req_ready_o = (state == IDLE) & ~flush_i;
   assign rsp_valid_o = (state == DONE);
   assign busy_o      = (state != IDLE);
   assign result_o    = result_q;

   assign op_in    = MULDIV_OP_t'(op_i);
   assign accept   = req_valid_i & req_ready_o;
   assign neg_a_in = op_signed_a(op_in) & rs1_i[XLEN-1];
   assign neg_b_in = op_signed_b(op_in) & rs2_i[XLEN-1];
   assign mag_a    = neg_a_in ? -rs1_i : rs1_i;
   assign mag_b    = neg_b_in ? -rs2_i : rs2_i;
   assign div0_in  = op_is_div(op_in) & (rs2_i == '0);
   assign ovf_in   = op_is_div(op_in) & op_signed_a(op_in)
                   & (rs1_i == SMIN) & (rs2_i == '1);

   // Step chain: BITS_PER_CYCLE iterations per CALC cycle
   logic [XLEN-1:0] hi_chain [BITS_PER_CYCLE+1];
   logic [XLEN-1:0] lo_chain [BITS_PER_CYCLE+1];
   logic            div_mode;

   assign div_mode    = op_is_div(op_q);
   assign hi_chain[0] = hi_q;
   assign lo_chain[0] = lo_q;

   for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
      muldiv_step #(.XLEN(XLEN)) u_step (
         .is_div  (div_mode),
         .hi      (hi_chain[g]),
         .lo      (lo_chain[g]),
         .operand (b_q),
         .hi_next (hi_chain[g+1]),
         .lo_next (lo_chain[g+1])
      );
   end

   // Sign fix-up and special-case select (used in SIGN)
   logic [2*XLEN-1:0] prod;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quot;
   logic [XLEN-1:0]   rem;
   logic [XLEN-1:0]   sign_res;

   always_comb begin
      prod     = {hi_q, lo_q};
      prod_fix = neg_res_q ? -prod : prod;
      quot     = neg_res_q ? -lo_q : lo_q;
      // Remainder takes the dividend's sign; with a zero divisor hi_q holds
      // the dividend magnitude, so this also restores rs1 unaltered.
      rem      = neg_a_q ? -hi_q : hi_q;
      if (div0_q) quot = MULDIV_DIV0_Q;
      if (ovf_q) begin
         quot = MULDIV_OVF_Q;
         rem  = '0;
      end
      case (op_q)
         MUL:                 sign_res = prod_fix[XLEN-1:0];
         MULH, MULHSU, MULHU: sign_res = prod_fix[2*XLEN-1:XLEN];
         DIV, DIVU:           sign_res = quot;
         default:             sign_res = rem;
      endcase
   end

`ifdef RV32M_DIV_SHORTCUT_EN
   logic [XLEN-1:0] short_res;

   always_comb begin
      if (op_in inside {REM, REMU}) short_res = div0_in ? rs1_i : '0;
      else                          short_res = div0_in ? MULDIV_DIV0_Q : MULDIV_OVF_Q;
   end
`endif

   // Control: state and the visible result register
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         result_q <= '0;
      end else if (flush_i) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state <= CALC;
`ifdef RV32M_DIV_SHORTCUT_EN
                  if (div0_in | ovf_in) begin
                     state    <= DONE;
                     result_q <= short_res;
                  end
`endif
               end
            end
            CALC: if (cnt_q == CNT_W'(1)) state <= SIGN;
            SIGN: begin
               state    <= DONE;
               result_q <= sign_res;
            end
            DONE: if (rsp_ready_i) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Datapath: loaded on accept, stepped in CALC.
   // NOTE: these registers are deliberately not reset; each is written on
   // accept before it is ever read, so reset would only cost logic.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_q      <= op_in;
         neg_a_q   <= neg_a_in;
         neg_res_q <= neg_a_in ^ neg_b_in;
         div0_q    <= div0_in;
         ovf_q     <= ovf_in;
         hi_q      <= '0;
         lo_q      <= mag_a;
         b_q       <= mag_b;
         cnt_q     <= CNT_W'(N);
      end else if (state == CALC) begin
         hi_q  <= hi_chain[BITS_PER_CYCLE];
         lo_q  <= lo_chain[BITS_PER_CYCLE];
         cnt_q <= cnt_q - 1'b1;
      end
   end

endmodule

// File: tb/tb_rv32m_muldiv_seq.sv
// ----------------------------------------------------------------------------
// tb_rv32m_muldiv_seq
// Self-checking bench for rv32m_muldiv_seq: directed cases for each op class,
// divide corner cases, response back-pressure, flush and reset aborts, and a
// random sweep against an arithmetic reference model. Honors
// RV32M_DIV_SHORTCUT_EN for the expected latency of corner-case divides.
// ----------------------------------------------------------------------------
module tb_rv32m_muldiv_seq;

   localparam int LAT_FULL = 34;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   localparam logic [31:0] SMIN = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [2:0]  op_i;
   logic [31:0] rs1_i;
   logic [31:0] rs2_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] result_o;
   logic        busy_o;

   int checks = 0;
   int errors = 0;

   rv32m_muldiv_seq dut (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (flush_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .op_i        (op_i),
      .rs1_i       (rs1_i),
      .rs2_i       (rs2_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .result_o    (result_o),
      .busy_o      (busy_o)
   );

   always #5 clk = ~clk;

   // Reference result from the RV32M arithmetic rules
   function automatic logic [31:0] ref_result(input logic [2:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
      logic [63:0] p;
      logic        ovf;
      ovf = (a == SMIN) && (b == 32'hFFFF_FFFF);
      case (op)
         OP_MUL: begin
            p = {32'h0, a} * {32'h0, b};
            return p[31:0];
         end
         OP_MULH: begin
            p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            return p[63:32];
         end
         OP_MULHSU: begin
            p = $signed({{32{a[31]}}, a}) * $signed({32'h0, b});
            return p[63:32];
         end
         OP_MULHU: begin
            p = {32'h0, a} * {32'h0, b};
            return p[63:32];
         end
         OP_DIV: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf)    return SMIN;
            return $signed(a) / $signed(b);
         end
         OP_DIVU: begin
            if (b == 0) return 32'hFFFF_FFFF;
            return a / b;
         end
         OP_REM: begin
            if (b == 0) return a;
            if (ovf)    return 32'h0;
            return $signed(a) % $signed(b);
         end
         default: begin
            if (b == 0) return a;
            return a % b;
         end
      endcase
   endfunction

   // Expected cycles from accept to the first cycle with rsp_valid_o high
   function automatic int ref_latency(input logic [2:0] op,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
      logic special;
      special = ((op == OP_DIV || op == OP_DIVU || op == OP_REM || op == OP_REMU) && b == 0)
             || ((op == OP_DIV || op == OP_REM) && a == SMIN && b == 32'hFFFF_FFFF);
`ifdef RV32M_DIV_SHORTCUT_EN
      if (special) return 1;
`else
      if (special) return LAT_FULL;
`endif
      return LAT_FULL;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present a request and let it be accepted on the next rising edge.
   // Returns #1 after the accept edge.
   task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      int w;
      w = 0;
      while (!req_ready_o && w < 100) begin
         @(posedge clk); #1;
         w++;
      end
      if (w >= 100) check("ready_timeout", 32'(w), 32'd0);
      req_valid_i = 1'b1;
      op_i        = op;
      rs1_i       = a;
      rs2_i       = b;
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      op_i        = 3'($urandom);
      rs1_i       = $urandom;
      rs2_i       = $urandom;
   endtask

   // Count cycles until rsp_valid_o, tracking busy_o along the way
   task automatic wait_rsp(output int lat, output logic busy_all);
      lat      = 1;
      busy_all = busy_o;
      while (!rsp_valid_o && lat < 200) begin
         @(posedge clk); #1;
         lat++;
         busy_all &= busy_o;
      end
   endtask

   task automatic run_check(input string tag, input logic [2:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp);
      int   lat;
      logic busy_all;
      start_op(op, a, b);
      wait_rsp(lat, busy_all);
      check({tag, "_res"},  result_o, exp);
      check({tag, "_lat"},  32'(lat), 32'(ref_latency(op, a, b)));
      check({tag, "_busy"}, 32'(busy_all), 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int          lat;
      logic        busy_all;
      logic        seen;
      logic [2:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      int          sel;

      rst         = 1'b1;
      flush_i     = 1'b0;
      req_valid_i = 1'b0;
      rsp_ready_i = 1'b1;
      op_i        = '0;
      rs1_i       = '0;
      rs2_i       = '0;
      repeat (3) @(posedge clk);
      #1;

      // Reset state
      check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      check("rst_result",    result_o,         32'd0);
      check("rst_busy",      32'(busy_o),      32'd0);
      check("rst_req_ready", 32'(req_ready_o), 32'd1);
      flush_i = 1'b1;
      #1;
      check("flush_blocks_ready", 32'(req_ready_o), 32'd0);
      flush_i = 1'b0;
      rst     = 1'b0;
      @(posedge clk); #1;

      // Multiply
      run_check("mul_7_m3",     OP_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB);
      run_check("mulh_min_min", OP_MULH,   SMIN,         SMIN,          32'h4000_0000);
      run_check("mulhu_ff_ff",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      run_check("mulhsu_ff_ff", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

      // Divide
      run_check("div_m7_2",    OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      run_check("rem_m7_2",    OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
      run_check("divu_100_7",  OP_DIVU, 32'd100,       32'd7, 32'd14);
      run_check("remu_100_7",  OP_REMU, 32'd100,       32'd7, 32'd2);

      // Divide corner cases
      run_check("div_5_0",     OP_DIV,  32'd5, 32'd0,         32'hFFFF_FFFF);
      run_check("rem_5_0",     OP_REM,  32'd5, 32'd0,         32'd5);
      run_check("rem_m5_0",    OP_REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);
      run_check("divu_5_0",    OP_DIVU, 32'd5, 32'd0,         32'hFFFF_FFFF);
      run_check("div_ovf",     OP_DIV,  SMIN,  32'hFFFF_FFFF, SMIN);
      run_check("rem_ovf",     OP_REM,  SMIN,  32'hFFFF_FFFF, 32'd0);

      // Back-pressure in DONE, then back-to-back op
      rsp_ready_i = 1'b0;
      start_op(OP_DIVU, 32'd100, 32'd7);
      wait_rsp(lat, busy_all);
      check("bp_first_res", result_o, 32'd14);
      repeat (5) begin
         @(posedge clk); #1;
         check("bp_hold_res",   result_o,         32'd14);
         check("bp_hold_valid", 32'(rsp_valid_o), 32'd1);
         check("bp_req_ready",  32'(req_ready_o), 32'd0);
      end
      rsp_ready_i = 1'b1;
      @(posedge clk); #1;
      check("bp_release_busy",  32'(busy_o),      32'd0);
      check("bp_release_ready", 32'(req_ready_o), 32'd1);
      run_check("b2b_remu", OP_REMU, 32'd100, 32'd7, 32'd2);

      // Flush in CALC cycle 10
      start_op(OP_MUL, 32'd123, 32'd456);
      repeat (9) @(posedge clk);
      #1;
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      check("flush_busy",  32'(busy_o),      32'd0);
      check("flush_valid", 32'(rsp_valid_o), 32'd0);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         seen |= rsp_valid_o | busy_o;
      end
      check("flush_quiet", 32'(seen), 32'd0);

      // Flush beats a same-cycle request
      flush_i     = 1'b1;
      req_valid_i = 1'b1;
      op_i        = OP_MUL;
      rs1_i       = 32'd3;
      rs2_i       = 32'd3;
      @(posedge clk); #1;
      flush_i     = 1'b0;
      req_valid_i = 1'b0;
      check("flush_vs_req_busy", 32'(busy_o), 32'd0);

      // Flush in DONE with rsp_ready_i also high
      rsp_ready_i = 1'b0;
      start_op(OP_MUL, 32'd6, 32'd7);
      wait_rsp(lat, busy_all);
      check("done_flush_res", result_o, 32'd42);
      flush_i     = 1'b1;
      rsp_ready_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      check("done_flush_valid", 32'(rsp_valid_o), 32'd0);
      check("done_flush_busy",  32'(busy_o),      32'd0);

      // Reset mid-op
      start_op(OP_DIV, 32'd1000, 32'd3);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_busy",   32'(busy_o),      32'd0);
      check("midrst_valid",  32'(rsp_valid_o), 32'd0);
      check("midrst_result", result_o,         32'd0);
      run_check("post_rst_mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

      // Random sweep against the reference model
      for (int i = 0; i < 40; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         sel = $urandom_range(0, 7);
         case (sel)
            0:       rb = 32'd0;
            1:       rb = 32'hFFFF_FFFF;
            2:       rb = 32'd1;
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 5) == 0) ra = SMIN;
         run_check($sformatf("rand%0d", i), rop, ra, rb, ref_result(rop, ra, rb));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
